// File: rtl/operand_scoreboard.sv
// Operand bypass and hazard-stall unit with a per-register scoreboard of in-flight long-latency writers.
// Forwarding stages are searched youngest-first; unresolved hazards raise a combinational stall.
module operand_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2,
  parameter int CNTW = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NREG)-1:0]   rs [NRD],
  input  logic [XLEN-1:0]           rq [NRD],
  input  logic                      issue_valid,
  input  logic [$clog2(NREG)-1:0]   issue_rd,
  input  logic                      issue_long,
  input  logic                      flush,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [$clog2(NREG)-1:0]   fwd_rd [NFWD],
  input  logic [NFWD-1:0]           fwd_ready,
  input  logic [XLEN-1:0]           fwd_data [NFWD],
  input  logic                      wb_valid,
  input  logic [$clog2(NREG)-1:0]   wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           opnd [NRD],
  output logic                      stall,
  output logic                      pending_any,
  output logic [63:0]               stall_cycles
);

  localparam int RW = $clog2(NREG);

  logic [CNTW-1:0] cnt      [NREG];
  logic [CNTW-1:0] cnt_next [NREG];
  logic [NRD-1:0]  port_stall;
  logic            hit;
  logic            waw_stall;
  logic            issue_eff;
  logic            any_next;

  always_comb begin
    port_stall = '0;
    hit        = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      opnd[p] = '0;
      hit     = 1'b0;
      if (rs[p] != '0) begin
        // The first matching stage decides alone, even when it is not ready yet.
        for (int i = 0; i < NFWD; i++) begin
          if (!hit && fwd_valid[i] && (fwd_rd[i] == rs[p])) begin
            hit = 1'b1;
            if (fwd_ready[i]) opnd[p] = fwd_data[i];
            else              port_stall[p] = 1'b1;
          end
        end
        if (!hit) begin
          if (cnt[rs[p]] == '0)
            opnd[p] = rq[p];
          else if ((cnt[rs[p]] == CNTW'(1)) && wb_valid && (wb_rd == rs[p]))
            opnd[p] = wb_data;
          else
            port_stall[p] = 1'b1;
        end
      end
    end
  end

  assign waw_stall = issue_valid && issue_long && (issue_rd != '0) && (cnt[issue_rd] == '1);
  assign stall     = (|port_stall) || waw_stall;
  assign issue_eff = issue_valid && !stall && !flush;

  // A decrement on an empty counter is a protocol error and is absorbed rather than wrapping.
  always_comb begin
    any_next = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = cnt[r];
      if (r != 0) begin
        if (issue_eff && issue_long && (issue_rd == RW'(r)) && !(wb_valid && (wb_rd == RW'(r))))
          cnt_next[r] = cnt[r] + CNTW'(1);
        else if (wb_valid && (wb_rd == RW'(r)) && !(issue_eff && issue_long && (issue_rd == RW'(r)))
                 && (cnt[r] != '0))
          cnt_next[r] = cnt[r] - CNTW'(1);
      end else begin
        cnt_next[r] = '0;
      end
      any_next = any_next || (cnt_next[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      pending_any  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
      pending_any  <= any_next;
      stall_cycles <= stall_cycles + 64'(stall);
    end
  end

endmodule
